// File: rtl/seq_divider_nb_pkg.sv
// Shared definitions for the sequential divider: operation encoding,
// FSM state encoding and small operation-decode helpers.
package seq_divider_nb_pkg;

   // RV32M divide/remainder operation encoding (op_i)
   localparam logic [1:0] DIV_OP_DIV  = 2'b00;
   localparam logic [1:0] DIV_OP_DIVU = 2'b01;
   localparam logic [1:0] DIV_OP_REM  = 2'b10;
   localparam logic [1:0] DIV_OP_REMU = 2'b11;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   // DIV and REM treat their operands as two's complement
   function automatic logic op_is_signed(input logic [1:0] op);
      return ~op[0];
   endfunction

   // REM and REMU return the remainder rather than the quotient
   function automatic logic op_is_rem(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/seq_divider_nb_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor and keep or restore the result.
// Kept separate so the step can be tested alone and unrolled for radix-4.
module div_step_nb #(
   parameter int N = 32
) (
   input  logic [N-1:0] rem,
   input  logic [N-1:0] quo,
   input  logic [N-1:0] divisor,
   output logic [N-1:0] next_rem,
   output logic [N-1:0] next_quo
);

   // Trial subtract at N+1 bits; the MSB is the borrow (negative result)
   logic [N:0] trial;
   assign trial = {rem, quo[N-1]} - {1'b0, divisor};

   // Keep the difference when it did not go negative, otherwise restore
   always_comb begin
      next_rem = {rem[N-2:0], quo[N-1]};
      next_quo = {quo[N-2:0], 1'b0};
      if (!trial[N]) begin
         next_rem = trial[N-1:0];
         next_quo = {quo[N-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider_nb.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU. Operands are
// taken on a valid/ready handshake in IDLE, one quotient bit is produced per
// BUSY cycle, and the result is held in DONE until the consumer takes it.
// Divide-by-zero and signed overflow are resolved at accept time and skip BUSY.
module seq_divider_nb
   import seq_divider_nb_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [1:0]   op_i,
   input  logic [N-1:0] dividend_i,
   input  logic [N-1:0] divisor_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [N-1:0] result_o,
   output logic         busy_o
);

   localparam int CNT_W = $clog2(N);
   localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(N - 1);

   // Two's-complement negate when requested; the most-negative value maps
   // onto itself, which is exactly its unsigned magnitude
   function automatic logic [N-1:0] cond_neg(input logic [N-1:0] v, input logic neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [1:0]       op_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [N-1:0]     rem_q;
   logic [N-1:0]     quo_q;
   logic [N-1:0]     dvs_q;
   logic [N-1:0]     result_q;

   logic             accept;
   logic             in_signed;
   logic             dvd_neg;
   logic             dvs_neg;
   logic             div_zero;
   logic             sgn_ovf;
   logic             special;
   logic [N-1:0]     special_result;
   logic [N-1:0]     step_rem;
   logic [N-1:0]     step_quo;
   logic [N-1:0]     final_result;

   // Accept-time decode of sign handling and the two short-cut cases
   always_comb begin
      accept    = (state_q == DIV_IDLE) && in_valid_i;
      in_signed = op_is_signed(op_i);
      dvd_neg   = in_signed & dividend_i[N-1];
      dvs_neg   = in_signed & divisor_i[N-1];
      div_zero  = (divisor_i == '0);
      sgn_ovf   = in_signed && (dividend_i == MOST_NEG) && (divisor_i == '1);
      special   = div_zero | sgn_ovf;
      if (div_zero) begin
         special_result = op_is_rem(op_i) ? dividend_i : '1;
      end else begin
         special_result = op_is_rem(op_i) ? '0 : MOST_NEG;
      end
   end

   div_step_nb #(.N(N)) u_step (
      .rem      (rem_q),
      .quo      (quo_q),
      .divisor  (dvs_q),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   // Sign-correct the last step's output; the flags are zero for unsigned ops
   always_comb begin
      if (op_is_rem(op_q)) begin
         final_result = cond_neg(step_rem, neg_rem_q);
      end else begin
         final_result = cond_neg(step_quo, neg_quo_q);
      end
   end

   // FSM state register
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= DIV_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake/status outputs
   always_comb begin
      state_d     = state_q;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      busy_o      = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) begin
               state_d = special ? DIV_DONE : DIV_BUSY;
            end
         end
         DIV_BUSY: begin
            busy_o = 1'b1;
            if (cnt_q == '0) begin
               state_d = DIV_DONE;
            end
         end
         DIV_DONE: begin
            busy_o      = 1'b1;
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               state_d = DIV_IDLE;
            end
         end
         default: state_d = DIV_IDLE;
      endcase
   end

   assign result_o = result_q;

   // Operand latch on accept, one restoring step per BUSY cycle, result capture
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q     <= '0;
         op_q      <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         result_q  <= '0;
      end else if (accept) begin
         op_q      <= op_i;
         neg_quo_q <= dvd_neg ^ dvs_neg;
         neg_rem_q <= dvd_neg;
         rem_q     <= '0;
         quo_q     <= cond_neg(dividend_i, dvd_neg);
         dvs_q     <= cond_neg(divisor_i, dvs_neg);
         cnt_q     <= CNT_START;
         if (special) begin
            result_q <= special_result;
         end
      end else if (state_q == DIV_BUSY) begin
         rem_q <= step_rem;
         quo_q <= step_quo;
         cnt_q <= cnt_q - 1'b1;
         if (cnt_q == '0) begin
            result_q <= final_result;
         end
      end
   end

endmodule

// File: tb/tb_seq_divider_nb.sv
// Self-checking bench for seq_divider_nb: directed cases from the test plan
// followed by randomized operations compared against an arithmetic model.
module tb_seq_divider_nb;

   localparam int N = 32;

   logic          clk;
   logic          rstn;
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    op;
   logic [N-1:0]  dividend;
   logic [N-1:0]  divisor;
   logic          out_valid;
   logic          out_ready;
   logic [N-1:0]  result;
   logic          busy;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   seq_divider_nb #(.N(N)) dut (
      .clk_i       (clk),
      .rstn_i      (rstn),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .op_i        (op),
      .dividend_i  (dividend),
      .divisor_i   (divisor),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .result_o    (result),
      .busy_o      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // RV32M semantics with plain integer arithmetic
   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      case (o)
         2'b01: return a / b;
         2'b11: return a % b;
         2'b00: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return 32'(sa / sb);
         end
         default: begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return 32'(sa % sb);
         end
      endcase
   endfunction

   function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // One complete transaction: present, wait for the result, apply
   // backpressure for 'hold' cycles, then hand the result off
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int hold, input logic [31:0] exp, input string tag);
      int start;
      int waited;
      int exp_lat;
      logic [31:0] held;
      @(negedge clk);
      check({tag, "_in_ready_idle"}, {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1;
      op       = o;
      dividend = a;
      divisor  = b;
      start    = cyc;
      @(negedge clk);
      in_valid = 1'b0;
      op       = 2'($urandom);
      dividend = $urandom;
      divisor  = $urandom;
      waited   = 0;
      while (!out_valid && waited < 4 * N) begin
         @(negedge clk);
         waited++;
      end
      if (!out_valid) begin
         check({tag, "_timeout"}, {31'd0, out_valid}, 32'd1);
         return;
      end
      exp_lat = is_special(o, a, b) ? 1 : N + 1;
      check({tag, "_latency"}, 32'(cyc - start), 32'(exp_lat));
      check({tag, "_result"}, result, exp);
      check({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
      held = result;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
         check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
         check({tag, "_hold_result"}, result, held);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_release_valid"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_release_in_ready"}, {31'd0, in_ready}, 32'd1);
      check({tag, "_release_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;

      rstn      = 1'b0;
      in_valid  = 1'b0;
      op        = 2'b00;
      dividend  = '0;
      divisor   = '0;
      out_ready = 1'b0;

      #3;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_result", result, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;

      // Unsigned and signed basics
      run_op(2'b01, 32'd100, 32'd7, 0, 32'd14, "divu_100_7");
      run_op(2'b11, 32'd100, 32'd7, 0, 32'd2, "remu_100_7");
      run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFD, "div_m7_2");
      run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 32'hFFFF_FFFF, "rem_m7_2");
      run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 0, 32'hFFFF_FFFD, "div_7_m2");
      run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, 32'd1, "rem_7_m2");

      // Divide by zero and signed overflow
      run_op(2'b01, 32'h1234, 32'd0, 0, 32'hFFFF_FFFF, "divu_by0");
      run_op(2'b10, 32'h1234, 32'd0, 0, 32'h1234, "rem_by0");
      run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, "div_ovf");
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, "rem_ovf");
      run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 32'd0, "divu_ovf_ops");

      // Backpressure held for 10 cycles
      run_op(2'b01, 32'd1000, 32'd33, 10, 32'd30, "bp_divu");

      // Asynchronous reset in the middle of BUSY
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b01;
      dividend = 32'hDEAD_BEEF;
      divisor  = 32'd7;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (11) @(negedge clk);
      check("mid_busy", {31'd0, busy}, 32'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_in_ready", {31'd0, in_ready}, 32'd1);
      check("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check("arst_result", result, 32'd0);
      check("arst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      run_op(2'b01, 32'hFFFF_FFFF, 32'd3, 0, 32'h5555_5555, "post_rst_divu");

      // Randomized operations against the model
      for (int k = 0; k < 150; k++) begin
         ro = 2'($urandom);
         case ($urandom % 4)
            0:       ra = 32'h8000_0000;
            1:       ra = $urandom % 64;
            default: ra = $urandom;
         endcase
         case ($urandom % 6)
            0:       rb = 32'd0;
            1:       rb = ($urandom % 8) + 1;
            2:       rb = 32'hFFFF_FFFF;
            3:       rb = 32'h8000_0000;
            default: rb = $urandom;
         endcase
         run_op(ro, ra, rb, int'($urandom % 4), ref_div(ro, ra, rb), "rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seq_divider_nb.md
Name: seq_divider_Nb

Overview:
Multi-cycle restoring divider for the RV32M DIV/DIVU/REM/REMU operations. It is the subtract-and-shift counterpart to the combinational adder path in the ALU. It sits beside the ALU in the execute stage, uses a valid/ready handshake, and produces one quotient bit per clock.

Parameters:
N, 32, operand/result width in bits (N >= 4, power of two not required)

Ports:
clk_i  input  1  clock, rising edge
rstn_i  input  1  asynchronous, active-low reset
in_valid_i  input  1  operands/op presented
in_ready_o  output  1  divider can accept (high only in IDLE)
op_i  input  2  00 DIV (signed quot), 01 DIVU, 10 REM (signed rem), 11 REMU
dividend_i  input  N  dividend
divisor_i  input  N  divisor
out_valid_o  output  1  result valid
out_ready_i  input  1  consumer accepts result
result_o  output  N  quotient or remainder per latched op
busy_o  output  1  high in BUSY or DONE

Behaviour:
- Reset is asynchronous, active-low, and takes effect at any time, including mid-operation. On reset: state IDLE; in_ready_o=1; out_valid_o=0; result_o=0; busy_o=0; all internal registers cleared. An in-flight operation is discarded.
- FSM states:
  - IDLE: in_ready_o=1. When in_valid_i is high, the operands are accepted on the clock edge.
    - Accept, special case: go to DONE.
    - Accept, otherwise: go to BUSY with cnt=N-1.
  - BUSY: one iteration per cycle, then cnt decrements. When cnt==0, the iteration runs and the FSM goes to DONE.
  - DONE: out_valid_o=1 and result_o is held stable. When out_ready_i is high, the FSM goes to IDLE on that edge. A new operation cannot be accepted in the same cycle (in_ready_o is 0 in DONE).
- Accept actions:
  - Latch op.
  - Signed ops: sign_q = dividend[N-1]^divisor[N-1] and sign_r = dividend[N-1]. Load the magnitudes (two's-complement negate when negative). The most-negative value stays 2^(N-1) as an unsigned magnitude.
  - Unsigned ops: load the operands as-is, with signs = 0.
  - Initialise rem=0 and quo=dividend magnitude.
- Iteration (restoring):
  - t = {rem[N-1:0], quo[N-1]} - {1'b0, divisor_mag}, computed at N+1 bits.
  - If t is non-negative (MSB=0): rem=t[N-1:0], quo={quo[N-2:0],1}.
  - Else: rem={rem[N-2:0],quo[N-1]}, quo={quo[N-2:0],0}.
- Finalise when entering DONE from BUSY: result = quotient (negated if DIV and sign_q) or remainder (negated if REM and sign_r).
- Special cases, decided at accept. These skip BUSY and go to DONE on the next cycle:
  - divisor==0: DIV/DIVU give all-ones; REM/REMU give the dividend unchanged.
  - Signed overflow (DIV/REM, dividend=100..0, divisor=all-ones): DIV gives 100..0; REM gives 0.
- Latency:
  - Normal operation: out_valid_o rises N+1 edges after the accept edge (BUSY lasts N cycles).
  - Special cases: 1 edge after accept.
  - Throughput: one operation per N+2 cycles minimum.
- Inputs are only sampled on the accept edge. Changes to operands while BUSY have no effect.
- Backpressure: DONE is held indefinitely while out_ready_i=0, with the result stable.

Decomposition:
- Shared ALU package holds:
  - op encoding constants DIV_OP_DIV/DIVU/REM/REMU
  - FSM state encoding (IDLE, BUSY, DONE)
- One sub-module, div_step_Nb: a combinational N+1-bit trial subtract plus restore mux, with inputs rem, quo, divisor and outputs next rem, next quo. This lets the step be unit-tested and later unrolled for radix-4.

Test Plan:
1. DIVU 100/7 (N=32) -> out_valid_o at accept+33, result 14; REMU same operands -> 2.
2. DIV -7/2 -> 0xFFFFFFFD (-3); REM -7/2 -> 0xFFFFFFFF (-1); DIV 7/-2 -> -3; REM 7/-2 -> 1.
3. Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REM 0x1234/0 -> 0x1234; both valid at accept+1.
4. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; valid at accept+1. DIVU with the same operands -> 0 via the full-latency path.
5. Backpressure: hold out_ready_i=0 for 10 cycles after valid -> result stable, in_ready_o=0; then out_ready_i=1 -> IDLE next edge, in_ready_o=1.
6. Reset: assert rstn_i low at BUSY cycle 12 -> outputs immediately reset values; after release, a new DIVU 0xFFFFFFFF/3 -> 0x55555555 with full latency.
